// File: rtl/lcd_cfah_responder.sv
// LCD-side responder for the CFAH1602 (HD44780-style) parallel bus: DDRAM, AC, config state, busy timing.
// Optional sticky busy-violation flag o_busy_err when LCD_CFAH_RESPONDER_BUSY_ERR_EN is defined.
module lcd_cfah_responder #(
  parameter int G_BUSY_SHORT = 1850,
  parameter int G_BUSY_LONG  = 76000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic       i_en,
  input  logic [7:0] i_lcd_data,
  output logic [7:0] o_lcd_rdata,
  output logic       o_lcd_oe,
  output logic       o_busy,
  output logic [6:0] o_ac,
  output logic [2:0] o_dl_n_f,
  output logic [2:0] o_dcb,
  output logic [1:0] o_id_s,
  output logic       o_wr_val,
  output logic       o_wr_rs,
  output logic [7:0] o_wr_data,
  input  logic [6:0] i_dbg_addr,
  output logic [7:0] o_dbg_data
`ifdef LCD_CFAH_RESPONDER_BUSY_ERR_EN
  ,
  output logic       o_busy_err
`endif
);

  localparam int CNT_MAX = (G_BUSY_LONG > G_BUSY_SHORT) ? G_BUSY_LONG : G_BUSY_SHORT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(G_BUSY_SHORT - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(G_BUSY_LONG - 1);
  // The commit cycle plus 128 fill cycles are already part of the long busy time.
  localparam logic [CNT_W-1:0] TAIL_LOAD  = CNT_W'(G_BUSY_LONG - 129);

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_BUSY} state_t;
  typedef enum logic [1:0] {K_NONE, K_SHORT, K_LONG, K_CLEAR} kind_t;

  logic             rs_reg, rw_reg, en_reg, en_prev_reg;
  logic [7:0]       data_reg;
  logic             stb_rs_reg, stb_rw_reg;
  logic [7:0]       stb_data_reg;
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [6:0]       clr_addr_reg;
  logic [6:0]       ac_reg;
  logic [2:0]       dl_n_f_reg, dcb_reg;
  logic [1:0]       id_s_reg;
  logic             busy_reg, oe_reg, wr_val_reg, wr_rs_reg;
  logic [7:0]       rdata_reg, wr_data_reg;
  logic [7:0]       mem [0:127];
  logic [7:0]       ram_rd_reg, dbg_reg;

  logic       commit, accept;
  kind_t      kind;
  logic [6:0] ac_step;
  logic       ram_we;
  logic [6:0] ram_waddr;
  logic [7:0] ram_wdata;

  assign commit  = en_prev_reg & ~en_reg;
  assign accept  = commit & (state_reg == ST_IDLE);
  assign ac_step = id_s_reg[1] ? ac_reg + 7'd1 : ac_reg - 7'd1;

  always_comb begin
    kind = K_NONE;
    if (stb_rs_reg) begin
      kind = K_SHORT;
    end else if (!stb_rw_reg) begin
      casez (stb_data_reg)
        8'b1???????, 8'b01??????, 8'b001?????,
        8'b0001????, 8'b00001???, 8'b000001??: kind = K_SHORT;
        8'b0000001?:                           kind = K_LONG;
        8'b00000001:                           kind = K_CLEAR;
        default:                               kind = K_NONE;
      endcase
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ac_reg;
    ram_wdata = stb_data_reg;
    if (state_reg == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_reg;
      ram_wdata = 8'h20;
    end else if (accept && !stb_rw_reg && stb_rs_reg) begin
      ram_we = 1'b1;
    end
  end

  // DDRAM is deliberately left out of reset so a partial clear keeps untouched bytes.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rd_reg <= mem[ac_reg];
    dbg_reg    <= mem[i_dbg_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_reg       <= 1'b0;
      rw_reg       <= 1'b0;
      en_reg       <= 1'b0;
      en_prev_reg  <= 1'b0;
      data_reg     <= 8'h00;
      stb_rs_reg   <= 1'b0;
      stb_rw_reg   <= 1'b0;
      stb_data_reg <= 8'h00;
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      clr_addr_reg <= 7'd0;
      ac_reg       <= 7'd0;
      dl_n_f_reg   <= 3'b100;
      dcb_reg      <= 3'b000;
      id_s_reg     <= 2'b10;
      busy_reg     <= 1'b0;
      oe_reg       <= 1'b0;
      rdata_reg    <= 8'h00;
      wr_val_reg   <= 1'b0;
      wr_rs_reg    <= 1'b0;
      wr_data_reg  <= 8'h00;
    end else begin
      rs_reg      <= i_rs;
      rw_reg      <= i_rw;
      en_reg      <= i_en;
      en_prev_reg <= en_reg;
      data_reg    <= i_lcd_data;
      if (en_reg) begin
        stb_rs_reg   <= rs_reg;
        stb_rw_reg   <= rw_reg;
        stb_data_reg <= data_reg;
      end
      oe_reg     <= en_reg & rw_reg;
      rdata_reg  <= (en_reg && rw_reg) ? (rs_reg ? ram_rd_reg : {busy_reg, ac_reg}) : 8'h00;
      wr_val_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (!stb_rw_reg) begin
              wr_val_reg  <= 1'b1;
              wr_rs_reg   <= stb_rs_reg;
              wr_data_reg <= stb_data_reg;
            end
            if (stb_rs_reg) begin
              ac_reg <= ac_step;
            end else if (!stb_rw_reg) begin
              casez (stb_data_reg)
                8'b1???????: ac_reg     <= stb_data_reg[6:0];
                8'b001?????: dl_n_f_reg <= stb_data_reg[4:2];
                8'b00001???: dcb_reg    <= stb_data_reg[2:0];
                8'b000001??: id_s_reg   <= stb_data_reg[1:0];
                8'b0000001?: ac_reg     <= 7'd0;
                8'b00000001: begin
                  ac_reg      <= 7'd0;
                  id_s_reg[1] <= 1'b1;
                end
                default: ;
              endcase
            end
            case (kind)
              K_SHORT: begin
                state_reg <= ST_BUSY;
                cnt_reg   <= SHORT_LOAD;
                busy_reg  <= 1'b1;
              end
              K_LONG: begin
                state_reg <= ST_BUSY;
                cnt_reg   <= LONG_LOAD;
                busy_reg  <= 1'b1;
              end
              K_CLEAR: begin
                state_reg    <= ST_CLEAR;
                clr_addr_reg <= 7'd0;
                busy_reg     <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_CLEAR: begin
          clr_addr_reg <= clr_addr_reg + 7'd1;
          if (clr_addr_reg == 7'd127) begin
            if (G_BUSY_LONG > 128) begin
              state_reg <= ST_BUSY;
              cnt_reg   <= TAIL_LOAD;
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LCD_CFAH_RESPONDER_BUSY_ERR_EN
  logic busy_err_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_err_reg <= 1'b0;
    end else if (commit && state_reg != ST_IDLE && (!stb_rw_reg || stb_rs_reg)) begin
      busy_err_reg <= 1'b1;
    end
  end
  assign o_busy_err = busy_err_reg;
`endif

  assign o_lcd_rdata = rdata_reg;
  assign o_lcd_oe    = oe_reg;
  assign o_busy      = busy_reg;
  assign o_ac        = ac_reg;
  assign o_dl_n_f    = dl_n_f_reg;
  assign o_dcb       = dcb_reg;
  assign o_id_s      = id_s_reg;
  assign o_wr_val    = wr_val_reg;
  assign o_wr_rs     = wr_rs_reg;
  assign o_wr_data   = wr_data_reg;
  assign o_dbg_data  = dbg_reg;

endmodule

// File: tb/tb_lcd_cfah_responder.sv
// Directed bench for lcd_cfah_responder with short busy times (20 / 200 cycles).
module tb_lcd_cfah_responder;
  localparam int SHORT = 20;
  localparam int LONG  = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rs = 1'b0, i_rw = 1'b0, i_en = 1'b0;
  logic [7:0] i_lcd_data = 8'h00;
  logic [6:0] i_dbg_addr = 7'd0;
  logic [7:0] o_lcd_rdata, o_wr_data, o_dbg_data;
  logic       o_lcd_oe, o_busy, o_wr_val, o_wr_rs;
  logic [6:0] o_ac;
  logic [2:0] o_dl_n_f, o_dcb;
  logic [1:0] o_id_s;
`ifdef LCD_CFAH_RESPONDER_BUSY_ERR_EN
  logic       o_busy_err;
`endif

  int tests = 0;
  int failed = 0;

  lcd_cfah_responder #(.G_BUSY_SHORT(SHORT), .G_BUSY_LONG(LONG)) dut (
    .clk(clk), .rst_n(rst_n), .i_rs(i_rs), .i_rw(i_rw), .i_en(i_en),
    .i_lcd_data(i_lcd_data), .o_lcd_rdata(o_lcd_rdata), .o_lcd_oe(o_lcd_oe),
    .o_busy(o_busy), .o_ac(o_ac), .o_dl_n_f(o_dl_n_f), .o_dcb(o_dcb),
    .o_id_s(o_id_s), .o_wr_val(o_wr_val), .o_wr_rs(o_wr_rs), .o_wr_data(o_wr_data),
    .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
`ifdef LCD_CFAH_RESPONDER_BUSY_ERR_EN
    , .o_busy_err(o_busy_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Strobe held 3 cycles; returns just after the commit edge.
  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    i_rs = rs; i_rw = 1'b0; i_lcd_data = d; i_en = 1'b1;
    repeat (3) @(negedge clk);
    i_en = 1'b0;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] rd, output logic oe);
    @(negedge clk);
    i_rs = rs; i_rw = 1'b1; i_en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rd = o_lcd_rdata; oe = o_lcd_oe;
    @(negedge clk); @(negedge clk);
    i_en = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    i_rw = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (o_busy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic dbg_read(input logic [6:0] a, output logic [7:0] d);
    @(negedge clk);
    i_dbg_addr = a;
    @(posedge clk); #1;
    d = o_dbg_data;
  endtask

  initial begin
    int n;
    logic [7:0] rd;
    logic oe;

    repeat (3) @(posedge clk);
    #1;
    check("rst_oe", o_lcd_oe, 1'b0);
    check("rst_rdata", o_lcd_rdata, 8'h00);
    check("rst_busy", o_busy, 1'b0);
    check("rst_ac", o_ac, 7'd0);
    check("rst_dlnf", o_dl_n_f, 3'b100);
    check("rst_dcb", o_dcb, 3'b000);
    check("rst_ids", o_id_s, 2'b10);
    check("rst_wrval", o_wr_val, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    bus_read(1'b0, rd, oe);
    check("rd0_data", rd, 8'h00);
    check("rd0_oe_strobe", oe, 1'b1);
    check("rd0_oe_after", o_lcd_oe, 1'b0);
    check("rd0_rdata_after", o_lcd_rdata, 8'h00);

    bus_write(1'b0, 8'h38);
    check("fs_wrval", o_wr_val, 1'b1);
    check("fs_wrdata", o_wr_data, 8'h38);
    check("fs_wrrs", o_wr_rs, 1'b0);
    check("fs_dlnf", o_dl_n_f, 3'b110);
    wait_idle(n);
    check("fs_busy_cycles", n, SHORT);
    bus_write(1'b0, 8'h0F);
    check("dc_dcb", o_dcb, 3'b111);
    wait_idle(n);
    check("dc_busy_cycles", n, SHORT);
    bus_write(1'b0, 8'h06);
    check("em_ids", o_id_s, 2'b10);
    wait_idle(n);
    check("em_busy_cycles", n, SHORT);

    bus_write(1'b0, 8'hFF);
    check("ac127", o_ac, 7'd127);
    wait_idle(n);
    bus_write(1'b1, 8'h41);
    check("wrap_up_ac", o_ac, 7'd0);
    check("data_wrrs", o_wr_rs, 1'b1);
    wait_idle(n);
    dbg_read(7'd127, rd);
    check("ddram127", rd, 8'h41);
    bus_write(1'b0, 8'h04);
    check("em_dec_ids", o_id_s, 2'b00);
    wait_idle(n);
    bus_write(1'b1, 8'h42);
    check("wrap_dn_ac", o_ac, 7'd127);
    wait_idle(n);
    dbg_read(7'd0, rd);
    check("ddram0", rd, 8'h42);

    bus_write(1'b0, 8'h06); wait_idle(n);
    bus_write(1'b0, 8'h80); wait_idle(n);
    bus_write(1'b1, 8'h55); wait_idle(n);
    check("ac_after_55", o_ac, 7'd1);
    bus_write(1'b0, 8'h80); wait_idle(n);
    bus_read(1'b1, rd, oe);
    check("rd1_data", rd, 8'h55);
    check("rd1_ac_step", o_ac, 7'd1);
    check("rd1_busy", o_busy, 1'b1);
    bus_read(1'b0, rd, oe);
    check("rd_bf_during_busy", rd, 8'h81);
    wait_idle(n);

    bus_write(1'b0, 8'h01);
    check("clr_ac", o_ac, 7'd0);
    wait_idle(n);
    check("clr_busy_cycles", n, LONG);
    dbg_read(7'd0, rd);   check("clr_mem0", rd, 8'h20);
    dbg_read(7'd64, rd);  check("clr_mem64", rd, 8'h20);
    dbg_read(7'd127, rd); check("clr_mem127", rd, 8'h20);

    bus_write(1'b0, 8'h8A); wait_idle(n); bus_write(1'b1, 8'h11); wait_idle(n);
    bus_write(1'b0, 8'hB1); wait_idle(n); bus_write(1'b1, 8'h44); wait_idle(n);
    bus_write(1'b0, 8'hB2); wait_idle(n); bus_write(1'b1, 8'h33); wait_idle(n);
    bus_write(1'b0, 8'hBC); wait_idle(n); bus_write(1'b1, 8'h77); wait_idle(n);
    bus_write(1'b0, 8'hFF); wait_idle(n); bus_write(1'b1, 8'h66); wait_idle(n);
    bus_write(1'b0, 8'h01);
    repeat (50) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", o_busy, 1'b0);
    check("abort_ac", o_ac, 7'd0);
    @(negedge clk) rst_n = 1'b1;
    dbg_read(7'd10, rd);  check("part_mem10", rd, 8'h20);
    dbg_read(7'd49, rd);  check("part_mem49", rd, 8'h20);
    dbg_read(7'd50, rd);  check("part_mem50", rd, 8'h33);
    dbg_read(7'd60, rd);  check("part_mem60", rd, 8'h77);
    dbg_read(7'd127, rd); check("part_mem127", rd, 8'h66);

    bus_write(1'b0, 8'h85); wait_idle(n);
    bus_write(1'b0, 8'h02);
    check("home_ac", o_ac, 7'd0);
    bus_write(1'b1, 8'h41);
    check("ign_wrval", o_wr_val, 1'b0);
    check("ign_ac", o_ac, 7'd0);
`ifdef LCD_CFAH_RESPONDER_BUSY_ERR_EN
    check("ign_busy_err", o_busy_err, 1'b1);
`endif
    wait_idle(n);
    check("home_idle", o_busy, 1'b0);
    dbg_read(7'd0, rd);
    check("ign_mem0", rd, 8'h20);
`ifdef LCD_CFAH_RESPONDER_BUSY_ERR_EN
    check("busy_err_sticky", o_busy_err, 1'b1);
    @(negedge clk) rst_n = 1'b0;
    #1 check("busy_err_reset", o_busy_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
